// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Tag entries track each granted request; buffer entries carry {pc, inst} toward decode.
package if_fetch_unit_pkg;

   localparam int          IMEM_AW      = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

   typedef struct packed {
      logic [IMEM_AW-1:0] pc;
      logic               epoch;
   } fetch_tag_t;

   typedef struct packed {
      logic [IMEM_AW-1:0] pc;
      logic [31:0]        inst;
   } ibuf_entry_t;

   function automatic logic [IMEM_AW-1:0] align_word(input logic [IMEM_AW-1:0] addr);
      return addr & ~IMEM_AW'(3);
   endfunction

endpackage

// File: rtl/if_fetch_unit_sync_fifo.sv
// Small first-word-fall-through FIFO with flush; head entry is visible combinationally.
// Used both as the outstanding-request tag queue and as the instruction buffer.
module if_sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_empty,
   output logic             o_full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, in-order imem requests with epoch-tagged
// responses, and a small instruction buffer delivering {pc, inst} to decode.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          MAX_OUTSTD = 2,
   parameter int          BUF_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] npc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [31:0] fetch_pc
);

   localparam int TCW = $clog2(MAX_OUTSTD + 1);
   localparam int BCW = $clog2(BUF_DEPTH + 1);

   logic [31:0]    r_pc;
   logic           r_epoch;

   fetch_tag_t     w_tag_in;
   fetch_tag_t     w_tag_out;
   logic [TCW-1:0] w_outstd;
   logic           w_tag_empty;
   logic           w_tag_full;

   ibuf_entry_t    w_buf_in;
   ibuf_entry_t    w_buf_head;
   logic [BCW-1:0] w_buf_count;
   logic           w_buf_empty;
   logic           w_buf_full;

   logic           w_issue;
   logic           w_resp;
   logic           w_keep;
   logic           w_id_pop;
   logic [31:0]    w_inflight;
   logic           w_unused_full;

   assign w_id_pop   = !w_buf_empty && id_ready;

   // Every outstanding request owns a buffer slot; a pop this cycle frees one,
   // which is what sustains one instruction per cycle with a two-entry buffer.
   assign w_inflight = 32'(w_outstd) + 32'(w_buf_count) - {31'd0, w_id_pop};

   assign imem_req   = !rst && !redirect
                    && (32'(w_outstd) < 32'(MAX_OUTSTD))
                    && (w_inflight < 32'(BUF_DEPTH));
   assign imem_addr  = r_pc;
   assign fetch_pc   = r_pc;

   assign w_issue    = imem_req && imem_gnt;
   assign w_resp     = imem_rvalid && !w_tag_empty;
   // A response arriving alongside a redirect belongs to the abandoned path.
   assign w_keep     = w_resp && (w_tag_out.epoch == r_epoch) && !redirect;

   assign w_tag_in   = '{pc: r_pc, epoch: r_epoch};
   assign w_buf_in   = '{pc: w_tag_out.pc, inst: imem_rdata};

   assign id_valid   = !w_buf_empty;
   assign id_pc      = w_buf_empty ? 32'd0 : w_buf_head.pc;
   assign id_inst    = w_buf_empty ? 32'd0 : w_buf_head.inst;

   assign w_unused_full = w_tag_full | w_buf_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_epoch <= 1'b0;
      end else if (redirect) begin
         r_pc    <= align_word(npc);
         r_epoch <= ~r_epoch;
      end else if (w_issue) begin
         r_pc    <= r_pc + 32'd4;
      end
   end

   if_sync_fifo #(
      .WIDTH ($bits(fetch_tag_t)),
      .DEPTH (MAX_OUTSTD)
   ) u_tag_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_issue),
      .i_data  (w_tag_in),
      .i_pop   (w_resp),
      .i_flush (1'b0),
      .o_data  (w_tag_out),
      .o_count (w_outstd),
      .o_empty (w_tag_empty),
      .o_full  (w_tag_full)
   );

   if_sync_fifo #(
      .WIDTH ($bits(ibuf_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_inst_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_keep),
      .i_data  (w_buf_in),
      .i_pop   (w_id_pop),
      .i_flush (redirect),
      .o_data  (w_buf_head),
      .o_count (w_buf_count),
      .o_empty (w_buf_empty),
      .o_full  (w_buf_full)
   );

`ifndef SYNTHESIS
   // A response with nothing outstanding is a memory-side protocol violation.
   a_rvalid_needs_outstanding: assert property (
      @(posedge clk) disable iff (rst) imem_rvalid |-> !w_tag_empty
   );

   a_buf_no_overflow: assert property (
      @(posedge clk) disable iff (rst) (w_keep && w_buf_full) |-> w_id_pop
   );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder with in-order random latency and a
// program-order model of which {pc, inst} decode must see next.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [31:0] fetch_pc;

   if_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .npc         (npc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .fetch_pc    (fetch_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   pend_t       pend[$];
   logic [31:0] pop_log[$];
   logic [31:0] exp_pc = 32'h0;
   int          gnt_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   logic        rst_rvalid = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        s_req;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_pc;
   int          n_pops = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a ^ 32'h5A5A_C3C3) * 32'h9E37_79B1) + 32'h13;
   endfunction

   // One clock cycle: drive memory side, observe, update model, advance to next negedge.
   task automatic cycle();
      imem_gnt = ($urandom_range(99, 0) < gnt_pct);
      if (rst) begin
         imem_rvalid = rst_rvalid;
         imem_rdata  = $urandom;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = id_valid;
      s_pc    = id_pc;
      if (!rst) begin
         if (redirect) begin
            checks++;
            if (imem_req !== 1'b0)
               $display("FAIL redirect_req cyc=%0d got %b expected 0", cyc, imem_req);
            if (imem_req !== 1'b0) errors++;
         end
         checks++;
         if (imem_req === 1'b1 && pend.size() >= 2) begin
            errors++;
            $display("FAIL outstanding_bound cyc=%0d got %0d outstanding with req=1, limit 2", cyc, pend.size());
         end
         if (imem_req === 1'b1) begin
            checks++;
            if (imem_addr[1:0] !== 2'b00) begin
               errors++;
               $display("FAIL addr_align cyc=%0d got %h expected word aligned", cyc, imem_addr);
            end
         end
         if (prev_hold && imem_req === 1'b1) begin
            checks++;
            if (imem_addr !== prev_addr) begin
               errors++;
               $display("FAIL addr_hold cyc=%0d got %h expected %h", cyc, imem_addr, prev_addr);
            end
         end
         if (id_valid === 1'b1 && id_ready) begin
            checks += 2;
            if (id_pc !== exp_pc) begin
               errors++;
               $display("FAIL id_pc cyc=%0d got %h expected %h", cyc, id_pc, exp_pc);
            end
            if (id_inst !== mem_word(exp_pc)) begin
               errors++;
               $display("FAIL id_inst cyc=%0d got %h expected %h", cyc, id_inst, mem_word(exp_pc));
            end
            $display("POP cyc=%0d pc=%h inst=%h", cyc, id_pc, id_inst);
            pop_log.push_back(id_pc);
            n_pops++;
            exp_pc = exp_pc + 32'd4;
         end
         if (imem_req === 1'b1 && imem_gnt)
            pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         if (imem_rvalid) void'(pend.pop_front());
         if (redirect) exp_pc = {npc[31:2], 2'b00};
         prev_hold = (imem_req === 1'b1) && !imem_gnt;
         prev_addr = imem_addr;
      end else begin
         pend.delete();
         exp_pc    = 32'h0;
         prev_hold = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic wait_two_outstanding(input string tag);
      int n = 0;
      while (pend.size() < 2 && n < 10) begin
         cycle();
         n++;
      end
      checks++;
      if (pend.size() != 2) begin
         errors++;
         $display("FAIL %s_setup got %0d outstanding expected 2", tag, pend.size());
      end
   endtask

   task automatic test_reset();
      checks += 5;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", imem_req); end
      if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", id_valid); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h expected 0", id_pc); end
      if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h expected 0", id_inst); end
      if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_fetch_pc got %h expected 0", fetch_pc); end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      gnt_pct = 100; lat_min = 1; lat_max = 1; id_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         cycle();
         checks++;
         if (s_req !== 1'b1 || s_addr !== 32'(4 * c)) begin
            errors++;
            $display("FAIL stream_addr c=%0d got req=%b addr=%h expected req=1 addr=%h", c, s_req, s_addr, 32'(4 * c));
         end
         if (c >= 2) begin
            checks++;
            if (s_valid !== 1'b1 || s_pc !== 32'(4 * (c - 2))) begin
               errors++;
               $display("FAIL stream_id c=%0d got valid=%b pc=%h expected valid=1 pc=%h", c, s_valid, s_pc, 32'(4 * (c - 2)));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] held_pc = 32'h0;
      int          pops0;
      id_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (i == 3) held_pc = s_pc;
         if (i >= 3) begin
            checks += 2;
            if (s_req !== 1'b0) begin
               errors++;
               $display("FAIL stall_req i=%0d got %b expected 0", i, s_req);
            end
            if (s_valid !== 1'b1 || s_pc !== held_pc) begin
               errors++;
               $display("FAIL stall_hold i=%0d got valid=%b pc=%h expected valid=1 pc=%h", i, s_valid, s_pc, held_pc);
            end
         end
      end
      id_ready = 1'b1;
      pops0 = n_pops;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (n_pops - pops0 < 7) begin
         errors++;
         $display("FAIL stall_resume got %0d pops expected at least 7", n_pops - pops0);
      end
   endtask

   task automatic redirect_and_check(input string tag, input logic [31:0] target,
                                     input logic [31:0] first, input logic [31:0] second);
      redirect = 1'b1; npc = target;
      cycle();
      redirect = 1'b0;
      checks++;
      if (s_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_req got %b expected 0", tag, s_req);
      end
      checks++;
      if (fetch_pc !== first) begin
         errors++;
         $display("FAIL %s_fetch_pc got %h expected %h", tag, fetch_pc, first);
      end
      pop_log.delete();
      for (int i = 0; i < 15; i++) cycle();
      checks++;
      if (pop_log.size() < 2 || pop_log[0] !== first || pop_log[1] !== second) begin
         errors++;
         $display("FAIL %s_order got %0d pops first=%h expected %h then %h", tag, pop_log.size(),
                  (pop_log.size() > 0) ? pop_log[0] : 32'hx, first, second);
      end
   endtask

   task automatic test_redirect_outstanding();
      lat_min = 3; lat_max = 3;
      wait_two_outstanding("redir100");
      redirect_and_check("redir100", 32'h0000_0100, 32'h0000_0100, 32'h0000_0104);
   endtask

   task automatic test_redirect_unaligned();
      lat_min = 1; lat_max = 1;
      redirect_and_check("redir203", 32'h0000_0203, 32'h0000_0200, 32'h0000_0204);
   endtask

   task automatic test_redirect_wrap();
      redirect_and_check("redir_wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
   endtask

   task automatic test_reset_midstream();
      lat_min = 3; lat_max = 3;
      wait_two_outstanding("rst_mid");
      rst = 1'b1;
      #1;
      checks += 5;
      if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req got %b expected 0", imem_req); end
      if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b expected 0", id_valid); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_id_pc got %h expected 0", id_pc); end
      if (id_inst !== 32'h0) begin errors++; $display("FAIL rst_mid_id_inst got %h expected 0", id_inst); end
      if (fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_fetch_pc got %h expected 0", fetch_pc); end
      rst_rvalid = 1'b1;
      cycle();
      cycle();
      rst_rvalid = 1'b0;
      rst = 1'b0;
      lat_min = 1; lat_max = 1;
      pop_log.delete();
      cycle();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_restart got req=%b addr=%h expected req=1 addr=00000000", s_req, s_addr);
      end
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (pop_log.size() < 2 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4) begin
         errors++;
         $display("FAIL rst_mid_order got %0d pops first=%h expected 00000000 then 00000004",
                  pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 32'hx);
      end
   endtask

   task automatic test_random();
      int since_redir = 100;
      int pops0 = n_pops;
      gnt_pct = 70; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         id_ready = ($urandom_range(3, 0) != 0);
         // Wrong-path responses must drain before the next redirect can reuse the epoch value.
         if (since_redir >= 6 && $urandom_range(39, 0) == 0) begin
            redirect = 1'b1;
            npc = $urandom;
            since_redir = 0;
         end else begin
            redirect = 1'b0;
            since_redir++;
         end
         cycle();
      end
      redirect = 1'b0; id_ready = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      checks++;
      if (n_pops - pops0 < 200) begin
         errors++;
         $display("FAIL random_progress got %0d pops expected at least 200", n_pops - pops0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; npc = 32'h0; id_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect_outstanding();
      test_redirect_unaligned();
      test_redirect_wrap();
      test_reset_midstream();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
